// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB-first, optional parity, one stop bit,
// each bit held for prescale clk cycles. tx_out and busy are registered.
module uart_tx_frame #(
   parameter int DATA_WIDTH = 8,
   parameter int PRE_W      = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic [PRE_W-1:0]      prescale,
   output logic                  tx_out,
   output logic                  busy
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                  state;
   logic [PRE_W-1:0]        pre_q;
   logic [PRE_W-1:0]        cyc_cnt;
   logic [IDX_W-1:0]        bit_idx;
   logic [DATA_WIDTH-1:0]   data_q;
   logic                    par_en_q;
   logic                    par_bit_q;
   logic                    last_cyc;

   function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
      return odd ? ~^d : ^d;
   endfunction

   function automatic logic [PRE_W-1:0] norm_prescale(input logic [PRE_W-1:0] p);
      return (p == '0) ? PRE_W'(1) : p;
   endfunction

   assign last_cyc = (cyc_cnt == pre_q - PRE_W'(1));

   // data_q is shifted right as each data bit is launched, so bit 0 is always the next one out
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tx_out    <= 1'b1;
         busy      <= 1'b0;
         cyc_cnt   <= '0;
         bit_idx   <= '0;
         data_q    <= '0;
         pre_q     <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx_out  <= 1'b1;
               busy    <= 1'b0;
               cyc_cnt <= '0;
               bit_idx <= '0;
               if (data_valid) begin
                  data_q    <= p_data;
                  par_en_q  <= par_en;
                  par_bit_q <= calc_parity(p_data, par_typ);
                  pre_q     <= norm_prescale(prescale);
                  state     <= START;
                  tx_out    <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            START: begin
               if (last_cyc) begin
                  cyc_cnt <= '0;
                  bit_idx <= '0;
                  tx_out  <= data_q[0];
                  data_q  <= data_q >> 1;
                  state   <= DATA;
               end else begin
                  cyc_cnt <= cyc_cnt + PRE_W'(1);
               end
            end
            DATA: begin
               if (last_cyc) begin
                  cyc_cnt <= '0;
                  if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                     if (par_en_q) begin
                        tx_out <= par_bit_q;
                        state  <= PARITY;
                     end else begin
                        tx_out <= 1'b1;
                        state  <= STOP;
                     end
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                     tx_out  <= data_q[0];
                     data_q  <= data_q >> 1;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + PRE_W'(1);
               end
            end
            PARITY: begin
               if (last_cyc) begin
                  cyc_cnt <= '0;
                  tx_out  <= 1'b1;
                  state   <= STOP;
               end else begin
                  cyc_cnt <= cyc_cnt + PRE_W'(1);
               end
            end
            STOP: begin
               if (last_cyc) begin
                  cyc_cnt <= '0;
                  tx_out  <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  cyc_cnt <= cyc_cnt + PRE_W'(1);
               end
            end
            default: begin
               state  <= IDLE;
               tx_out <= 1'b1;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a per-cycle scoreboard of expected {busy, tx_out} is filled at each
// acceptance and drained on every falling edge; an empty scoreboard means the line must idle.
module tb_uart_tx_frame;

   logic       clk;
   logic       rst;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_en;
   logic       par_typ;
   logic [4:0] prescale;
   logic       tx_out;
   logic       busy;

   typedef struct packed {
      logic busy;
      logic tx;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   vectors;
   int   miscompares;
   int   cycle;
   logic mon_en;

   uart_tx_frame #(.DATA_WIDTH(8), .PRE_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .prescale   (prescale),
      .tx_out     (tx_out),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      cycle <= cycle + 1;
      if (mon_en) begin
         if (exp_q.size() > 0) cur = exp_q.pop_front();
         else                  cur = '{busy: 1'b0, tx: 1'b1};
         vectors++;
         assert ({busy, tx_out} === {cur.busy, cur.tx}) else begin
            miscompares++;
            $error("FAIL line cycle %0d: observed busy,tx=%b%b expected %b%b",
                   cycle, busy, tx_out, cur.busy, cur.tx);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void push_bit(input logic b, input int p);
      for (int k = 0; k < p; k++) exp_q.push_back('{busy: 1'b1, tx: b});
   endfunction

   function automatic void push_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                                      input logic [4:0] pre);
      int p;
      p = (pre == 0) ? 1 : int'(pre);
      push_bit(1'b0, p);
      for (int i = 0; i < 8; i++) push_bit(d[i], p);
      if (pen) push_bit(ptyp ? ~^d : ^d, p);
      push_bit(1'b1, p);
   endfunction

   // Called at posedge+1 with the DUT idle; returns at posedge+1 right after acceptance.
   task automatic send(input logic [7:0] d, input logic pen, input logic ptyp,
                       input logic [4:0] pre);
      p_data     = d;
      par_en     = pen;
      par_typ    = ptyp;
      prescale   = pre;
      data_valid = 1'b1;
      @(posedge clk); #1;
      data_valid = 1'b0;
      push_frame(d, pen, ptyp, pre);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      assert (exp_q.size() == 0) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected cycles left, required 0", tag, exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_busy_low(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 400);
      vectors++;
      assert (busy === 1'b0) else begin
         miscompares++;
         $error("FAIL %s: observed busy=%b after %0d cycles, required 0", tag, busy, n);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cycle       = 0;
      mon_en      = 1'b0;
      rst         = 1'b1;
      p_data      = 8'h00;
      data_valid  = 1'b0;
      par_en      = 1'b0;
      par_typ     = 1'b0;
      prescale    = 5'd1;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      vectors++;
      assert ({busy, tx_out} === 2'b01) else begin
         miscompares++;
         $error("FAIL reset_state: observed busy,tx=%b%b required 01", busy, tx_out);
      end
      repeat (3) @(posedge clk);
      #1;

      // P=4, no parity, 8'hA5
      send(8'hA5, 1'b0, 1'b0, 5'd4);
      wait_done("frame_a5_p4");

      // P=8, even then odd parity on 8'h07
      send(8'h07, 1'b1, 1'b0, 5'd8);
      wait_done("frame_07_even");
      send(8'h07, 1'b1, 1'b1, 5'd8);
      wait_done("frame_07_odd");

      // prescale 0 behaves as 1
      send(8'h00, 1'b0, 1'b0, 5'd0);
      wait_done("frame_00_p0");

      // data_valid held high across three words
      p_data     = 8'h11;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      prescale   = 5'd4;
      data_valid = 1'b1;
      @(posedge clk); #1;
      push_frame(8'h11, 1'b0, 1'b0, 5'd4);
      exp_q.push_back('{busy: 1'b0, tx: 1'b1});
      push_frame(8'h22, 1'b0, 1'b0, 5'd4);
      exp_q.push_back('{busy: 1'b0, tx: 1'b1});
      push_frame(8'h33, 1'b0, 1'b0, 5'd4);
      p_data = 8'h22;
      wait_busy_low("b2b_first");
      @(posedge clk); #1;
      p_data = 8'h33;
      wait_busy_low("b2b_second");
      @(posedge clk); #1;
      data_valid = 1'b0;
      wait_done("b2b_three");

      // reset for two cycles during data bit 3
      send(8'h3C, 1'b0, 1'b0, 5'd4);
      repeat (17) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      vectors++;
      assert ({busy, tx_out} === 2'b01) else begin
         miscompares++;
         $error("FAIL midframe_reset: observed busy,tx=%b%b required 01", busy, tx_out);
      end
      repeat (20) @(posedge clk);
      #1;

      // reset and data_valid together: the word is dropped
      rst        = 1'b1;
      data_valid = 1'b1;
      p_data     = 8'hF0;
      @(posedge clk); #1;
      rst        = 1'b0;
      data_valid = 1'b0;
      vectors++;
      assert ({busy, tx_out} === 2'b01) else begin
         miscompares++;
         $error("FAIL rst_wins: observed busy,tx=%b%b required 01", busy, tx_out);
      end
      repeat (15) @(posedge clk);
      #1;

      // mid-frame request and input changes are ignored
      send(8'hC3, 1'b0, 1'b0, 5'd4);
      repeat (6) @(posedge clk);
      #1;
      p_data     = 8'h5A;
      prescale   = 5'd2;
      par_en     = 1'b1;
      par_typ    = 1'b1;
      data_valid = 1'b1;
      @(posedge clk); #1;
      data_valid = 1'b0;
      wait_done("midframe_ignore");
      repeat (30) @(posedge clk);
      #1;

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
